// File: rtl/reflet_mem_pkg.sv
// Shared memory-map constants, FSM state encoding and address decode for the
// Reflet boot mapper.
package reflet_mem_pkg;

  localparam logic [15:0] DEF_ROM_BASE  = 16'h7E00;
  localparam logic [15:0] DEF_ROM_TOP   = 16'h7FFF;
  localparam logic [15:0] DEF_CTRL_ADDR = 16'hFF00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ROM  = 2'd1,
    RD_RAM  = 2'd2,
    RD_CTRL = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_ROM  = 2'd1,
    REG_CTRL = 2'd2
  } region_e;

  // The control register wins over the window so a parameterisation that
  // overlaps the two still leaves the register reachable.
  function automatic region_e decode_addr(
    input logic [15:0] addr,
    input logic        boot_active,
    input logic [15:0] rom_base,
    input logic [15:0] rom_top,
    input logic [15:0] ctrl_addr
  );
    if (addr == ctrl_addr) begin
      return REG_CTRL;
    end else if (boot_active && (addr >= rom_base) && (addr <= rom_top)) begin
      return REG_ROM;
    end else begin
      return REG_RAM;
    end
  endfunction

endpackage

// File: rtl/reflet_boot_mapper.sv
// Overlays the bootloader ROM onto the CPU address space until software
// clears the boot control register; all other traffic goes to RAM.
module reflet_boot_mapper #(
  parameter logic [15:0] ROM_BASE  = reflet_mem_pkg::DEF_ROM_BASE,
  parameter logic [15:0] ROM_TOP   = reflet_mem_pkg::DEF_ROM_TOP,
  parameter logic [15:0] CTRL_ADDR = reflet_mem_pkg::DEF_CTRL_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic [14:0] rom_addr,
  output logic        rom_enable,
  input  logic [7:0]  rom_data,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_write,
  output logic        ram_enable,
  input  logic [7:0]  ram_rdata,
  output logic        boot_active
);
  import reflet_mem_pkg::*;

  state_e      state_q, state_d;
  logic        boot_active_q, boot_active_d;
  logic [14:0] rom_addr_q, rom_addr_d;
  region_e     region;

  always_comb begin
    region = decode_addr(cpu_addr, boot_active_q, ROM_BASE, ROM_TOP, CTRL_ADDR);
  end

  always_comb begin
    state_d       = state_q;
    boot_active_d = boot_active_q;
    rom_addr_d    = rom_addr_q;
    cpu_ready     = 1'b0;
    cpu_rdata     = 8'h00;
    rom_enable    = 1'b0;
    rom_addr      = rom_addr_q;
    ram_addr      = cpu_addr;
    ram_wdata     = cpu_wdata;
    ram_write     = 1'b0;
    ram_enable    = 1'b0;

    case (state_q)
      IDLE: begin
        rom_addr = cpu_addr[14:0];
        if (cpu_write) begin
          cpu_ready = 1'b1;
          if (region == REG_CTRL) begin
            if (!cpu_wdata[0]) boot_active_d = 1'b0;
          end else begin
            // Window writes shadow into RAM even while the ROM is mapped.
            ram_write  = 1'b1;
            ram_enable = 1'b1;
          end
        end else if (cpu_read) begin
          rom_addr_d = cpu_addr[14:0];
          case (region)
            REG_ROM: begin
              rom_enable = 1'b1;
              state_d    = RD_ROM;
            end
            REG_CTRL: state_d = RD_CTRL;
            default: begin
              ram_enable = 1'b1;
              state_d    = RD_RAM;
            end
          endcase
        end
      end
      RD_ROM: begin
        // Keep the ROM enabled so its registered output is not disturbed.
        rom_enable = 1'b1;
        cpu_ready  = 1'b1;
        cpu_rdata  = rom_data;
        state_d    = IDLE;
      end
      RD_RAM: begin
        cpu_ready = 1'b1;
        cpu_rdata = ram_rdata;
        state_d   = IDLE;
      end
      RD_CTRL: begin
        cpu_ready = 1'b1;
        cpu_rdata = {7'b0, boot_active_q};
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are quiet for the whole reset cycle, including an abandoned read.
    if (!reset) begin
      cpu_ready  = 1'b0;
      cpu_rdata  = 8'h00;
      rom_enable = 1'b0;
      ram_enable = 1'b0;
      ram_write  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      boot_active_q <= 1'b1;
      rom_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      boot_active_q <= boot_active_d;
      rom_addr_q    <= rom_addr_d;
    end
  end

  assign boot_active = boot_active_q;

endmodule

// File: tb/tb_reflet_boot_mapper.sv
// Self-checking bench for reflet_boot_mapper: directed scenarios plus random
// traffic checked against a memory-map reference model.
module tb_reflet_boot_mapper;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic [14:0] rom_addr;
  logic        rom_enable;
  logic [7:0]  rom_data = '0;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_write;
  logic        ram_enable;
  logic [7:0]  ram_rdata = '0;
  logic        boot_active;

  int vectors = 0;
  int miscompares = 0;

  reflet_boot_mapper dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .rom_addr(rom_addr), .rom_enable(rom_enable), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_write(ram_write),
    .ram_enable(ram_enable), .ram_rdata(ram_rdata),
    .boot_active(boot_active)
  );

  always #5 clk = ~clk;

  // External memories: ROM content is a fixed function of the address.
  logic [7:0] ram_mem [0:65535];

  function automatic logic [7:0] rom_content(input logic [15:0] a);
    return a[7:0] ^ 8'h10;
  endfunction

  always @(posedge clk) begin
    if (rom_enable) rom_data <= rom_content({1'b0, rom_addr});
    if (ram_enable) begin
      if (ram_write) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model of the CPU-visible memory map.
  logic [7:0] ref_ram [int];
  logic       ref_boot = 1'b1;

  function automatic bit is_ctrl(input logic [15:0] a);
    return a == 16'hFF00;
  endfunction

  function automatic bit model_hits_rom(input logic [15:0] a);
    return ref_boot && !is_ctrl(a) && (int'(a) >= 'h7E00) && (int'(a) <= 'h7FFF);
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    if (is_ctrl(a)) return {7'b0, ref_boot};
    if (model_hits_rom(a)) return rom_content(a);
    if (ref_ram.exists(int'(a))) return ref_ram[int'(a)];
    return 8'h00;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (cpu_ready !== 1'b0 || cpu_rdata !== 8'h00 || rom_enable !== 1'b0 ||
        ram_enable !== 1'b0 || ram_write !== 1'b0 || boot_active !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b rdata=%h rom_en=%b ram_en=%b ram_wr=%b boot=%b, required 0 00 0 0 0 1",
               cpu_ready, cpu_rdata, rom_enable, ram_enable, ram_write, boot_active);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    ref_boot = 1'b1;
    $display("reset applied, boot_active=%b", boot_active);
  endtask

  task automatic do_read(input logic [15:0] a);
    logic [7:0] exp_data;
    bit exp_rom, exp_ram;
    exp_data = model_read(a);
    exp_rom  = model_hits_rom(a);
    exp_ram  = !exp_rom && !is_ctrl(a);
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = a;
    @(negedge clk);
    vectors++;
    if (cpu_ready !== 1'b0 || rom_enable !== exp_rom || ram_enable !== exp_ram || ram_write !== 1'b0) begin
      miscompares++;
      $display("FAIL read_issue @%h: ready=%b rom_en=%b ram_en=%b ram_wr=%b, required 0 %b %b 0",
               a, cpu_ready, rom_enable, ram_enable, ram_write, exp_rom, exp_ram);
    end
    vectors++;
    if ((exp_rom && rom_addr !== a[14:0]) || (exp_ram && ram_addr !== a)) begin
      miscompares++;
      $display("FAIL read_issue_addr @%h: rom_addr=%h ram_addr=%h", a, rom_addr, ram_addr);
    end
    @(negedge clk);
    vectors++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== exp_data) begin
      miscompares++;
      $display("FAIL read_data @%h: ready=%b rdata=%h, required 1 %h", a, cpu_ready, cpu_rdata, exp_data);
    end
    vectors++;
    if (ram_enable !== 1'b0 || rom_enable !== exp_rom) begin
      miscompares++;
      $display("FAIL read_wait_strobes @%h: rom_en=%b ram_en=%b, required %b 0", a, rom_enable, ram_enable, exp_rom);
    end
    @(posedge clk); #1;
    cpu_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (cpu_ready !== 1'b0 || cpu_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL read_single_ready @%h: ready=%b rdata=%h, required 0 00", a, cpu_ready, cpu_rdata);
    end
    $display("read  %h -> %h (expected %h, %s)", a, cpu_rdata, exp_data,
             exp_rom ? "rom" : (exp_ram ? "ram" : "ctrl"));
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit with_read);
    bit to_ram;
    to_ram = !is_ctrl(a);
    @(posedge clk); #1;
    cpu_write = 1'b1; cpu_read = with_read; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    vectors++;
    if (cpu_ready !== 1'b1 || ram_write !== to_ram || ram_enable !== to_ram || rom_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL write_strobes @%h: ready=%b ram_wr=%b ram_en=%b rom_en=%b, required 1 %b %b 0",
               a, cpu_ready, ram_write, ram_enable, rom_enable, to_ram, to_ram);
    end
    vectors++;
    if (to_ram && (ram_addr !== a || ram_wdata !== d)) begin
      miscompares++;
      $display("FAIL write_bus @%h: ram_addr=%h ram_wdata=%h, required %h %h", a, ram_addr, ram_wdata, a, d);
    end
    if (to_ram) ref_ram[int'(a)] = d;
    else if (!d[0]) ref_boot = 1'b0;
    @(posedge clk); #1;
    cpu_write = 1'b0; cpu_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (cpu_ready !== 1'b0 || ram_enable !== 1'b0 || boot_active !== ref_boot) begin
      miscompares++;
      $display("FAIL write_after @%h: ready=%b ram_en=%b boot=%b, required 0 0 %b",
               a, cpu_ready, ram_enable, boot_active, ref_boot);
    end
    $display("write %h <- %h%s boot_active=%b", a, d, with_read ? " (with read)" : "", boot_active);
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_rom_read();
    do_read(16'h7E00);
  endtask

  task automatic test_shadow_write();
    do_write(16'h7E05, 8'hA5, 1'b0);
    do_read(16'h7E05);
  endtask

  task automatic test_clear_boot();
    do_write(16'hFF00, 8'h00, 1'b0);
    do_read(16'h7E05);
    do_read(16'hFF00);
  endtask

  task automatic test_read_write_collision();
    do_write(16'h0100, 8'h3C, 1'b1);
    do_read(16'h0100);
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_addr = 16'h7E10;
    @(negedge clk);
    vectors++;
    if (rom_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_issue: rom_en=%b, required 1", rom_enable);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (cpu_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_ready cycle %0d: ready=%b, required 0", i, cpu_ready);
      end
    end
    cpu_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    ref_boot = 1'b1;
    @(negedge clk);
    vectors++;
    if (boot_active !== 1'b1 || cpu_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_after: boot=%b ready=%b, required 1 0", boot_active, cpu_ready);
    end
    $display("reset during rom read: read abandoned, boot_active=%b", boot_active);
  endtask

  task automatic test_boundaries();
    do_read(16'h7DFF);
    do_read(16'h8000);
    do_read(16'h7FFF);
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  d;
    int op;
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 3))
        0: a = 16'h7E00 + 16'($urandom_range(0, 'h1FF));
        1: begin
          case ($urandom_range(0, 3))
            0: a = 16'h7DFF;
            1: a = 16'h7E00;
            2: a = 16'h7FFF;
            default: a = 16'h8000;
          endcase
        end
        2: a = 16'($urandom_range(0, 'hFF));
        default: a = 16'($urandom);
      endcase
      d  = 8'($urandom);
      op = $urandom_range(0, 9);
      if (op <= 3) do_read(a);
      else if (op <= 6) do_write(a, d, 1'b0);
      else if (op == 7) begin
        if ($urandom_range(0, 15) != 0) d[0] = 1'b1;
        do_write(16'hFF00, d, 1'b0);
      end
      else if (op == 8) do_read(16'hFF00);
      else do_write(a, d, 1'b1);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram_mem[i] = 8'h00;
    test_reset();
    test_rom_read();
    test_shadow_write();
    test_clear_boot();
    test_read_write_collision();
    test_reset_mid_read();
    test_boundaries();
    apply_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
